// File: rtl/fir_out_requant.sv
// fir_out_requant: back end of the fir_filter datapath.
// Requantises each unsigned filter result to OUT_W bits (round-half-up,
// right shift, saturation) and buffers it in a first-word-fall-through FIFO
// behind a valid/ready interface. The input side is never stalled: a sample
// arriving at a full FIFO with no pop on the same edge is dropped and the
// sticky ovf flag is raised.
module fir_out_requant #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    // Rounding offset 2^(SHIFT-1) and the largest representable output,
    // both in the IN_W+1 bit domain used by the rounding sum.
    localparam logic [IN_W:0] HALF    = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [IN_W:0] OUT_MAX = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Returns {sat, result}: round-half-up, shift right, clamp to OUT_W bits.
    function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
        logic [IN_W:0]  sum_v;
        logic [IN_W:0]  q_v;
        logic [OUT_W:0] res_v;
        sum_v = {1'b0, x} + HALF;
        q_v   = sum_v >> SHIFT;
        if (q_v > OUT_MAX) begin
            res_v = {1'b1, {OUT_W{1'b1}}};
        end else begin
            res_v = {1'b0, q_v[OUT_W-1:0]};
        end
        return res_v;
    endfunction

    // Stage 1 holds one requantised word ({sat, data}) in flight.
    logic               s1_v_r;
    logic [OUT_W:0]     s1_word_r;

    // FIFO storage and bookkeeping.
    logic [OUT_W:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic [OUT_W:0]     out_word_r;

    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic [PTR_W-1:0]   rd_next_s;
    logic [PTR_W-1:0]   wr_next_s;
    logic [CNT_W-1:0]   count_next_s;
    logic [OUT_W:0]     head_next_s;
    logic               ovf_next_s;

    // Push/pop decisions, next occupancy and the word that will sit at the head.
    always_comb begin
        pop_s     = out_valid_r & out_ready;
        push_s    = s1_v_r & ((count_r < DEPTH_C) | pop_s);
        drop_s    = s1_v_r & ~push_s;

        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end

        if (push_s) begin
            wr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_next_s = wr_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        // The write slot coincides with the new read slot only when the
        // incoming word becomes the sole entry, so it must bypass memory.
        if (count_next_s == CNT_ZERO) begin
            head_next_s = out_word_r;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = s1_word_r;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end

        // A drop on the same edge as a clear wins, so no loss goes unseen.
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Stage 1: requantise every strobed sample; no back-pressure exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r    <= 1'b0;
            s1_word_r <= {(OUT_W + 1){1'b0}};
        end else begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_word_r <= requant(in_data);
            end
        end
    end

    // FIFO storage write; contents need no reset because count gates them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s1_word_r;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_word_r  <= {(OUT_W + 1){1'b0}};
        end else begin
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            ovf_r       <= ovf_next_s;
            out_valid_r <= (count_next_s != CNT_ZERO);
            out_word_r  <= head_next_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_word_r[OUT_W-1:0];
    assign out_sat   = out_word_r[OUT_W];
    assign count     = count_r;
    assign ovf       = ovf_r;

endmodule
